// File: rtl/ocs_slot_scheduler.sv
// OCS timeslot scheduler: waits for all ToR links to be stable, then alternates
// CONFIG (OCS switching) and SLOT (data) phases, driving slot_id and sync pulses.
module ocs_slot_scheduler #(
  parameter int          P_CHANNEL_NUM  = 8,
  parameter int          P_SLOT_NUM     = 2,
  parameter int          P_SLOT_ID_W    = 1,
  parameter logic [31:0] P_LINK_STABLE  = 32'd16,
  parameter logic [31:0] P_CONFIG_DELAY = 32'h0000_00AA,
  parameter logic [31:0] P_SLOT_LEN     = 32'h0000_0753
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic                     i_mode,
  input  logic [P_CHANNEL_NUM-1:0] i_link_up,
  input  logic [31:0]              i_cfg_delay,
  input  logic [31:0]              i_slot_len,
  input  logic                     i_timing_load,
  output logic [P_SLOT_ID_W-1:0]   o_slot_id,
  output logic                     o_cfg_phase,
  output logic                     o_slot_valid,
  output logic [P_CHANNEL_NUM-1:0] o_sync,
  output logic                     o_sim_start,
  output logic                     o_link_lost,
  output logic [31:0]              o_slot_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_LINK, S_CONFIG, S_SLOT} state_t;

  localparam logic [P_SLOT_ID_W-1:0] LP_LAST_ID = P_SLOT_ID_W'(P_SLOT_NUM - 1);
  localparam logic [P_SLOT_ID_W-1:0] LP_ID_ONE  = P_SLOT_ID_W'(1);

  state_t                 r_state, w_next;
  logic [31:0]            r_stable_cnt, r_phase_cnt;
  logic [31:0]            r_cfg_pend, r_slot_pend, r_cfg_active, r_slot_active;
  logic                   r_sim_pend;
  logic [P_SLOT_ID_W-1:0] r_slot_id;
  logic [31:0]            r_slot_cnt;
  logic                   r_cfg_phase, r_slot_valid, r_sync, r_sim_start, r_link_lost;

  logic        w_all_up, w_link_drop, w_phase_last, w_stable_done;
  logic [31:0] w_cfg_len, w_slot_len, w_phase_len;
  logic        w_cfg_phase, w_slot_valid, w_sync, w_sim_start;

  assign w_all_up      = &i_link_up;
  assign w_link_drop   = ((r_state == S_CONFIG) || (r_state == S_SLOT)) && !w_all_up;
  // A programmed length of 0 still occupies one cycle.
  assign w_cfg_len     = (r_cfg_active == '0) ? 32'd1 : r_cfg_active;
  assign w_slot_len    = (r_slot_active == '0) ? 32'd1 : r_slot_active;
  assign w_phase_len   = (r_state == S_CONFIG) ? w_cfg_len : w_slot_len;
  assign w_phase_last  = (r_phase_cnt == w_phase_len - 32'd1);
  assign w_stable_done = w_all_up && (r_stable_cnt == P_LINK_STABLE - 32'd1);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_stable_cnt  <= '0;
      r_phase_cnt   <= '0;
      r_cfg_pend    <= P_CONFIG_DELAY;
      r_slot_pend   <= P_SLOT_LEN;
      r_cfg_active  <= P_CONFIG_DELAY;
      r_slot_active <= P_SLOT_LEN;
      r_sim_pend    <= 1'b0;
      r_slot_id     <= '0;
      r_slot_cnt    <= '0;
      r_cfg_phase   <= 1'b0;
      r_slot_valid  <= 1'b0;
      r_sync        <= 1'b0;
      r_sim_start   <= 1'b0;
      r_link_lost   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_stable_cnt <= (r_state == S_WAIT_LINK && w_all_up) ? r_stable_cnt + 32'd1 : '0;
      r_phase_cnt  <= (w_next != r_state) ? '0 : r_phase_cnt + 32'd1;

      if (i_timing_load) begin
        r_cfg_pend  <= i_cfg_delay;
        r_slot_pend <= i_slot_len;
      end
      // Timing changes only take effect at a slot boundary.
      if (w_next == S_CONFIG && r_state != S_CONFIG) begin
        r_cfg_active  <= r_cfg_pend;
        r_slot_active <= r_slot_pend;
      end

      if (r_state == S_SLOT && w_next == S_CONFIG && !i_mode)
        r_slot_id <= (r_slot_id == LP_LAST_ID) ? '0 : r_slot_id + LP_ID_ONE;
      if (r_state == S_SLOT && w_all_up && w_phase_last)
        r_slot_cnt <= r_slot_cnt + 32'd1;

      if (r_state == S_IDLE && w_next == S_WAIT_LINK)
        r_sim_pend <= 1'b1;
      else if (w_sync)
        r_sim_pend <= 1'b0;

      r_cfg_phase  <= w_cfg_phase;
      r_slot_valid <= w_slot_valid;
      r_sync       <= w_sync;
      r_sim_start  <= w_sim_start;
      r_link_lost  <= w_link_drop;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (i_enable) w_next = S_WAIT_LINK;
      S_WAIT_LINK: begin
        if (!i_enable)          w_next = S_IDLE;
        else if (w_stable_done) w_next = S_CONFIG;
      end
      S_CONFIG: begin
        if (!w_all_up)         w_next = S_WAIT_LINK;
        else if (!i_enable)    w_next = S_IDLE;
        else if (w_phase_last) w_next = S_SLOT;
      end
      S_SLOT: begin
        if (!w_all_up)         w_next = S_WAIT_LINK;
        else if (w_phase_last) w_next = i_enable ? S_CONFIG : S_IDLE;
      end
      default:                 w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with r_state.
  always_comb begin
    w_cfg_phase  = (w_next == S_CONFIG);
    w_slot_valid = (w_next == S_SLOT);
    w_sync       = (w_next == S_SLOT) && (r_state != S_SLOT);
    w_sim_start  = w_sync && r_sim_pend;
  end

  assign o_slot_id    = r_slot_id;
  assign o_cfg_phase  = r_cfg_phase;
  assign o_slot_valid = r_slot_valid;
  assign o_sync       = {P_CHANNEL_NUM{r_sync}};
  assign o_sim_start  = r_sim_start;
  assign o_link_lost  = r_link_lost;
  assign o_slot_cnt   = r_slot_cnt;

endmodule

// File: doc/ocs_slot_scheduler.md
Name: ocs_slot_scheduler

Overview:
- Parametrised timeslot scheduler for the OCS controller. Generalises the fixed 1-bit slot_id and fixed P_CONFIG_DELAY/P_SLOT_LEN timing to N slots, N ToR channels, runtime-loadable timing, and rotate/hold modes.
- Gates the first slot on all ToR links being stable, then alternates CONFIG (OCS switching) and SLOT (data) phases.
- Drives slot_id to the OCS planes, and per-channel sync pulses plus a one-shot simulation-start pulse to the ToR-facing trx ports.

Parameters:
- P_CHANNEL_NUM, 8, number of ToR channels / link_up bits.
- P_SLOT_NUM, 2, number of distinct slot ids, ≥2.
- P_SLOT_ID_W, 1, slot_id width, ≥ clog2(P_SLOT_NUM).
- P_LINK_STABLE, 32'd16, consecutive all-links-up cycles required before start.
- P_CONFIG_DELAY, 32'h0000_00AA, reset value of the config-phase length register.
- P_SLOT_LEN, 32'h0000_0753, reset value of the slot-phase length register.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_enable  in  1  run request
- i_mode  in  1  0 = rotate slot_id, 1 = hold slot_id
- i_link_up  in  P_CHANNEL_NUM  per-channel link-stable flags
- i_cfg_delay  in  32  runtime config-phase length
- i_slot_len  in  32  runtime slot-phase length
- i_timing_load  in  1  pulse; latch i_cfg_delay/i_slot_len into pending registers
- o_slot_id  out  P_SLOT_ID_W  current OCS slot id
- o_cfg_phase  out  1  high in CONFIG
- o_slot_valid  out  1  high in SLOT
- o_sync  out  P_CHANNEL_NUM  one-cycle time-sync pulse, all bits simultaneous
- o_sim_start  out  1  one-cycle pulse at the first SLOT after leaving WAIT_LINK from IDLE
- o_link_lost  out  1  one-cycle pulse on link drop while running
- o_slot_cnt  out  32  completed SLOT phases, wraps at 2^32

Behaviour:
- Reset (i_rst=1 at a clock edge), next cycle:
  - state IDLE; all outputs 0.
  - Pending and active timing registers = P_CONFIG_DELAY / P_SLOT_LEN; stable counter 0.
- States:
  - IDLE -> WAIT_LINK when i_enable=1.
  - WAIT_LINK: stable counter increments while &i_link_up, clears to 0 otherwise. When the count reaches P_LINK_STABLE-1 with &i_link_up -> CONFIG.
  - CONFIG: lasts cfg_active cycles, with 0 treated as 1. Then -> SLOT.
  - SLOT: lasts slot_active cycles, with 0 treated as 1. At the last cycle:
    - o_slot_cnt++.
    - If i_enable=0 -> IDLE; else -> CONFIG.
    - On the move to CONFIG, o_slot_id advances: (id+1 == P_SLOT_NUM) ? 0 : id+1 in rotate mode; unchanged in hold mode.
  - Any state other than IDLE, if i_enable=0 while not in SLOT -> IDLE next cycle.
- Timing load:
  - i_timing_load writes the pending registers.
  - Active registers copy pending on every CONFIG entry, so a change takes effect only at a slot boundary, never mid-phase.
- Registered outputs:
  - o_cfg_phase / o_slot_valid are registered and high exactly for the cycles the FSM is in CONFIG / SLOT.
  - o_sync = all ones in the first SLOT cycle of every slot.
  - o_sim_start is high in the same cycle as the first o_sync after each IDLE->WAIT_LINK pass.
- Link drop: in CONFIG or SLOT, if any i_link_up bit is 0:
  - o_link_lost pulses; state -> WAIT_LINK next cycle; o_slot_valid/o_cfg_phase drop.
  - o_slot_id is held; o_slot_cnt is not incremented for the aborted slot.
  - Re-entry does not re-pulse o_sim_start.
- Priority per cycle: i_rst > link drop > i_enable=0 > phase counter expiry.
- o_slot_id stays constant across SLOT and changes only in the first CONFIG cycle.

Test Plan:
- Params: CHANNEL=4, SLOT_NUM=3, LINK_STABLE=4, CONFIG_DELAY=4, SLOT_LEN=10, rotate mode, links all up at reset release, i_enable=1 -> first o_sync and o_sim_start on the same cycle; o_cfg_phase high 4 cycles before it; slot_id sequence 0,0→1→2→0 across SLOTs; period 14 cycles; o_slot_cnt=3 after third slot.
- Hold mode with the same setup -> slot_id stays 0 for 5 slots; o_sync every 14 cycles; o_sim_start only once.
- Link 2 toggles low every 3rd cycle during WAIT_LINK -> no CONFIG entry. After steady high, CONFIG starts exactly 4 cycles later.
- Drop link 1 at SLOT cycle 5 of slot_id 1 -> o_link_lost one pulse; slot_valid low next cycle; o_slot_cnt unchanged. After relink, the next SLOT still has slot_id 1 and no o_sim_start.
- i_timing_load with cfg=2, slot=6 mid-SLOT -> current slot finishes at 10 cycles; next CONFIG 2 cycles, SLOT 6. Separately, cfg=0 behaves as 1 cycle.
- i_enable low mid-SLOT -> SLOT completes, o_slot_cnt++, IDLE. i_rst asserted mid-CONFIG -> all outputs 0 next cycle, timing registers back to 4/10.
